// File: rtl/agc_seq_alu.sv
// ----------------------------------------------------------------------------
// agc_seq_alu
//   Sequential one's-complement ALU. AD/SU/MASK, MP1/DV1 and the reserved op
//   complete one cycle after start. MP0 (shift-add multiply) and DV0
//   (restoring divide) iterate one magnitude bit per cycle. Both leave the
//   double-width result in hi_reg/lo_reg. MP1/DV1 read hi_reg back.
//
//   Optional feature macro: AGC_ALU_OVF_EN
//     defined   : overflow pulses with done on AD/SU sign overflow
//     undefined : overflow is tied to 0 and no overflow logic is built
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset
//   start     in   1      one-cycle request, sampled only when busy==0
//   alu_op    in   3      0 AD, 1 SU, 2 MASK, 3 MP0, 4 MP1, 5 DV0, 6 DV1, 7 rsv
//   x         in   WIDTH  operand X (augend / multiplicand / dividend)
//   y         in   WIDTH  operand Y (addend / subtrahend / multiplier / divisor)
//   result    out  WIDTH  registered result, held until the next done
//   busy      out  1      high while an MP0/DV0 iteration is in progress
//   done      out  1      one-cycle pulse, result valid in the same cycle
//   div_zero  out  1      pulses with done when DV0 sees |y|==0
//   overflow  out  1      pulses with done on AD/SU overflow (macro enabled)
// ----------------------------------------------------------------------------
module agc_seq_alu #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int MW = WIDTH - 1;          // magnitude bits
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(MW - 1);

  typedef enum logic [2:0] {
    OP_AD   = 3'd0,
    OP_SU   = 3'd1,
    OP_MASK = 3'd2,
    OP_MP0  = 3'd3,
    OP_MP1  = 3'd4,
    OP_DV0  = 3'd5,
    OP_DV1  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e           r_state;
  logic             r_is_div;
  logic             r_xs;
  logic             r_ys;
  logic [MW-1:0]    r_acc;    // product high half / partial remainder
  logic [MW-1:0]    r_q;      // multiplier -> product low half / dividend -> quotient
  logic [MW-1:0]    r_opnd;   // multiplicand / divisor magnitude
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  op_e w_op;
  assign w_op = op_e'(alu_op);

  // ---- single-cycle datapath ----------------------------------------------
  logic [MW-1:0]    w_x_mag;
  logic [MW-1:0]    w_y_mag;
  logic [WIDTH-1:0] w_y_eff;
  logic [WIDTH:0]   w_add_raw;
  logic [WIDTH-1:0] w_add;
  logic             w_y_zero;
  logic             w_in_sign;

  assign w_x_mag   = x[MW] ? ~x[MW-1:0] : x[MW-1:0];
  assign w_y_mag   = y[MW] ? ~y[MW-1:0] : y[MW-1:0];
  // Subtraction is addition of the one's complement of y.
  assign w_y_eff   = (w_op == OP_SU) ? ~y : y;
  assign w_add_raw = {1'b0, x} + {1'b0, w_y_eff};
  // End-around carry; the fold cannot carry out again, so -0 survives intact.
  assign w_add     = w_add_raw[WIDTH-1:0] + {{MW{1'b0}}, w_add_raw[WIDTH]};
  assign w_y_zero  = (w_y_mag == '0);        // covers both +0 and -0
  assign w_in_sign = x[MW] ^ y[MW];

  // ---- iterative datapath -------------------------------------------------
  // Multiply: {acc,q} += opnd<<MW when q[0], then shift the pair right.
  logic [MW:0]   w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc} + ({1'b0, r_opnd} & {(MW+1){r_q[0]}});

  // Restoring divide: shift the next dividend bit in, subtract if it fits.
  logic [MW:0]   w_div_shift;
  logic          w_div_fits;
  logic [MW-1:0] w_div_rem;
  assign w_div_shift = {r_acc, r_q[MW-1]};
  assign w_div_fits  = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_rem   = MW'(w_div_shift - {1'b0, r_opnd});

  // ---- final sign application ---------------------------------------------
  logic             w_p_sign;
  logic             w_q_sign;
  logic             w_r_sign;
  logic [WIDTH-1:0] w_fin_hi;
  logic [WIDTH-1:0] w_fin_lo;

  // A zero magnitude always comes out as +0.
  assign w_p_sign = (r_xs ^ r_ys) & (|{r_acc, r_q});
  assign w_q_sign = (r_xs ^ r_ys) & (|r_q);
  assign w_r_sign = r_xs & (|r_acc);

  assign w_fin_hi = r_is_div ? {w_q_sign, r_q   ^ {MW{w_q_sign}}}
                             : {w_p_sign, r_acc ^ {MW{w_p_sign}}};
  assign w_fin_lo = r_is_div ? {w_r_sign, r_acc ^ {MW{w_r_sign}}}
                             : {w_p_sign, r_q   ^ {MW{w_p_sign}}};

  // ---- control FSM with registered outputs --------------------------------
  // NOTE: every register here is assigned with <= so all updates in a cycle
  // see the pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_div   <= 1'b0;
      r_xs       <= 1'b0;
      r_ys       <= 1'b0;
      r_acc      <= '0;
      r_q        <= '0;
      r_opnd     <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (w_op)
              OP_AD, OP_SU: begin
                r_result <= w_add;
                r_done   <= 1'b1;
              end
              OP_MASK: begin
                r_result <= x & y;
                r_done   <= 1'b1;
              end
              OP_MP1, OP_DV1: begin
                r_result <= r_hi;
                r_done   <= 1'b1;
              end
              OP_MP0: begin
                r_is_div <= 1'b0;
                r_xs     <= x[MW];
                r_ys     <= y[MW];
                r_acc    <= '0;
                r_q      <= w_y_mag;
                r_opnd   <= w_x_mag;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_state  <= S_ITER;
              end
              OP_DV0: begin
                if (w_y_zero) begin
                  // Quotient saturates to max magnitude, remainder is x.
                  r_hi       <= {w_in_sign, {MW{~w_in_sign}}};
                  r_lo       <= x;
                  r_result   <= x;
                  r_done     <= 1'b1;
                  r_div_zero <= 1'b1;
                end else begin
                  r_is_div <= 1'b1;
                  r_xs     <= x[MW];
                  r_ys     <= y[MW];
                  r_acc    <= '0;
                  r_q      <= w_x_mag;
                  r_opnd   <= w_y_mag;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_ITER;
                end
              end
              default: begin
                r_result <= '0;
                r_done   <= 1'b1;
              end
            endcase
          end
        end

        S_ITER: begin
          if (r_is_div) begin
            r_acc <= w_div_fits ? w_div_rem : w_div_shift[MW-1:0];
            r_q   <= {r_q[MW-2:0], w_div_fits};
          end else begin
            r_acc <= w_mul_sum[MW:1];
            r_q   <= {w_mul_sum[0], r_q[MW-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) r_state <= S_FINISH;
        end

        S_FINISH: begin
          r_hi     <= w_fin_hi;
          r_lo     <= w_fin_lo;
          r_result <= w_fin_lo;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result   = r_result;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

`ifdef AGC_ALU_OVF_EN
  // Operands share a sign but the sum does not.
  logic w_add_ovf;
  logic r_overflow;
  assign w_add_ovf = (x[MW] == w_y_eff[MW]) && (w_add[MW] != x[MW]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= (r_state == S_IDLE) && start &&
                    ((w_op == OP_AD) || (w_op == OP_SU)) && w_add_ovf;
    end
  end
  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule
